tdm_demux_4to1: RTL and testbench
=================================

Name: tdm_demux_4to1

Overview:
- Receive side of the 4:1 channel multiplexing path; the inverse of the 4-to-1 mux.
- Accepts a time-division-multiplexed word stream (slot order A, B, C, D, repeating) and steers each word to one of four registered channel outputs.
- Each channel output has its own valid/ready handshake.
- A start-of-frame marker realigns the slot counter. Misalignment is flagged and completed frames are counted.

Parameters:
- WIDTH, 8, data word width of the input and of each channel output.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an input word is present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sof  input  1  qualifies in_data as slot 0 (channel A) of a frame.
- A  output  WIDTH  channel A data (slot 0).
- B  output  WIDTH  channel B data (slot 1).
- C  output  WIDTH  channel C data (slot 2).
- D  output  WIDTH  channel D data (slot 3).
- out_valid  output  4  per-channel valid; bit 0=A … bit 3=D.
- out_ready  input  4  per-channel ready; same bit order.
- S1, S0  output  1 each  current expected slot (S1 is MSB); mirrors the mux select encoding.
- frame_err  output  1  one-cycle pulse on an SOF-misalignment event.
- frame_cnt  output  CNT_W  number of completed frames (slot-3 accepts), wraps.

Behaviour:

Reset (synchronous, rst=1 at a rising edge):
- slot={S1,S0}=0, out_valid=0, A..D=0, frame_err=0, frame_cnt=0.
- in_ready is combinational and may be high during reset, but no accept occurs while rst=1.
- Reset mid-operation discards all buffered words without emitting them.

Effective slot:
- slot_eff = in_sof ? 0 : slot.

Input handshake:
- in_ready = !out_valid[slot_eff] || out_ready[slot_eff].
- Accept = in_valid && in_ready && !rst.
- in_ready never depends on in_valid.

On accept:
- Channel register slot_eff is loaded with in_data and its out_valid bit is set.
- slot <= slot_eff+1, mod 4; slot 3 wraps to 0.
- Latency: the word appears on its channel output on the cycle after accept.

Channel registers:
- Each channel register holds data and valid stable until out_ready is high.
- out_valid[i] clears on out_ready[i] && out_valid[i], unless the same channel is reloaded in that cycle. A simultaneous drain and reload keeps valid=1 with the new data; no bubble.
- Channel data is unchanged when a channel is not loaded.

Frame error and frame count:
- frame_err=1 for exactly the cycle after an accept with in_sof=1 and slot!=0.
- The slot is still forced to 0, so the word goes to A.
- A partial frame's earlier words remain valid in their channels.
- frame_cnt increments on the cycle after any accept with slot_eff=3, and wraps from 2^CNT_W-1 to 0.
- An SOF with slot already 0 is legal, with no error.

Backpressure:
- A stalled channel blocks only when it is the current slot_eff.
- Other channels drain independently.
- No word is ever dropped or duplicated.

Idle:
- in_valid=0 leaves slot, channels and counter unchanged, apart from draining.

Decomposition:
- Package tdm_demux_pkg: NUM_CH=4, typedef slot_t (2-bit), constants SLOT_A=0, SLOT_B=1, SLOT_C=2, SLOT_D=3.
- Sub-module demux_chan_buf, instantiated 4×:
  - One-entry data/valid register with load, drain and ready-out logic.
  - Parameterised by WIDTH.
  - Same synchronous active-high rst.
- Top level contains the slot counter, SOF/error logic, frame counter and steering.

Test Plan:
- Reset then 4 accepts (in_sof=1 on the first) of 0x11,0x22,0x33,0x44 with out_ready=4'b1111:
  - A=0x11, B=0x22, C=0x33, D=0x44, each valid one cycle after its accept.
  - frame_cnt=1, slot back to 0, frame_err never asserted.
- out_ready[1]=0, stream 2 frames continuously:
  - in_ready drops when slot_eff=1 and B is full.
  - After out_ready[1]=1, B first shows frame-1 data, then frame-2 data.
  - No loss; frame_cnt=2.
- in_sof=1 on the 3rd word (slot=2), data 0x55:
  - frame_err pulses once.
  - A=0x55 the next cycle; S1S0=01 after accept.
  - frame_cnt unchanged.
- Simultaneous drain and reload on channel C (out_valid[2]=1, out_ready[2]=1, accept at slot 2 with 0x99):
  - out_valid[2] stays 1 and C=0x99 the next cycle.
- Assert rst after 2 accepted words:
  - Next cycle out_valid=0, A..D=0, S1S0=00, frame_cnt=0.
  - The next non-SOF word goes to A.
- CNT_W=2, 5 full frames:
  - frame_cnt goes 1,2,3,0,1.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg
// Shared definitions for the TDM 4:1 demultiplexer: channel count, the
// 2-bit slot type and the named slot constants (A..D map to slots 0..3,
// the same encoding the transmit-side mux uses for its select).
package tdm_demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_B = 2'd1;
    localparam slot_t SLOT_C = 2'd2;
    localparam slot_t SLOT_D = 2'd3;

    // Slot that follows s in the repeating A,B,C,D order.
    function automatic slot_t slot_after(input slot_t s);
        return slot_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// demux_chan_buf
// One-entry output register for a single demux channel.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   load           write load_data into the entry this cycle
//   load_data      word to store
//   drain_ready    downstream ready for this channel
//   data, valid    registered channel output and its valid flag
//   can_load       entry is empty or is being drained this cycle
module demux_chan_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             can_load
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    // A full entry may accept a new word in the same cycle it drains, so
    // back-to-back traffic through one channel has no bubble.
    assign can_load = !valid_reg || drain_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            // Reload wins over drain: valid stays set with the new word.
            data_reg  <= load_data;
            valid_reg <= 1'b1;
        end else if (valid_reg && drain_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/tdm_demux_4to1.sv
// tdm_demux_4to1
// Receive side of the 4:1 TDM channel path. Words arrive in slot order
// A,B,C,D and are steered into four registered channel outputs, each with
// its own valid/ready handshake. in_sof forces the current word to slot A;
// an SOF arriving anywhere but slot A pulses frame_err. Every accepted slot-D
// word completes a frame and bumps frame_cnt (wrapping).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input word handshake (in_ready independent of in_valid)
//   in_data, in_sof       input word and its start-of-frame qualifier
//   A, B, C, D            channel data outputs
//   out_valid/out_ready   per-channel handshake, bit 0 = A ... bit 3 = D
//   S1, S0                current expected slot (S1 = MSB)
//   frame_err             one-cycle misalignment pulse
//   frame_cnt             completed-frame counter
module tdm_demux_4to1
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             S1,
    output logic             S0,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    slot_t             slot_reg, slot_next, slot_eff;
    logic              frame_err_reg, frame_err_next;
    logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
    logic              accept;

    logic [WIDTH-1:0]  ch_data     [NUM_CH];
    logic [NUM_CH-1:0] ch_can_load;
    logic [NUM_CH-1:0] ch_load;

    // SOF overrides the running slot so a misaligned stream resyncs on the
    // marked word itself rather than one frame later.
    assign slot_eff = in_sof ? SLOT_A : slot_reg;
    assign in_ready = ch_can_load[slot_eff];
    assign accept   = in_valid && in_ready && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_load[gi] = accept && (slot_eff == slot_t'(gi));

            demux_chan_buf #(
                .WIDTH(WIDTH)
            ) u_buf (
                .clk        (clk),
                .rst        (rst),
                .load       (ch_load[gi]),
                .load_data  (in_data),
                .drain_ready(out_ready[gi]),
                .data       (ch_data[gi]),
                .valid      (out_valid[gi]),
                .can_load   (ch_can_load[gi])
            );
        end
    endgenerate

    always_comb begin
        slot_next      = slot_reg;
        frame_err_next = 1'b0;
        frame_cnt_next = frame_cnt_reg;
        if (accept) begin
            slot_next      = slot_after(slot_eff);
            frame_err_next = in_sof && (slot_reg != SLOT_A);
            if (slot_eff == SLOT_D) begin
                frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg      <= SLOT_A;
            frame_err_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            slot_reg      <= slot_next;
            frame_err_reg <= frame_err_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign A         = ch_data[SLOT_A];
    assign B         = ch_data[SLOT_B];
    assign C         = ch_data[SLOT_C];
    assign D         = ch_data[SLOT_D];
    assign S1        = slot_reg[1];
    assign S0        = slot_reg[0];
    assign frame_err = frame_err_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_tdm_demux_4to1.sv
// Testbench for tdm_demux_4to1: directed table, hand sequences for the
// multi-cycle corners, and randomized traffic against a reference model.
// A second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_tdm_demux_4to1;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_sof;
    logic [7:0] in_data;
    logic [3:0] out_ready;

    logic       in_ready, s1, s0, frame_err;
    logic [7:0] a_o, b_o, c_o, d_o, frame_cnt;
    logic [3:0] out_valid;

    logic       in_ready2, s1_2, s0_2, frame_err2;
    logic [7:0] a2, b2, c2, d2;
    logic [3:0] out_valid2;
    logic [1:0] frame_cnt2;

    always #5 clk = ~clk;

    tdm_demux_4to1 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .A(a_o), .B(b_o), .C(c_o), .D(d_o),
        .out_valid(out_valid), .out_ready(out_ready), .S1(s1), .S0(s0),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    tdm_demux_4to1 #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_sof(in_sof), .A(a2), .B(b2), .C(c2), .D(d2),
        .out_valid(out_valid2), .out_ready(out_ready), .S1(s1_2), .S0(s0_2),
        .frame_err(frame_err2), .frame_cnt(frame_cnt2)
    );

    logic [7:0] dch [4];
    assign dch[0] = a_o;
    assign dch[1] = b_o;
    assign dch[2] = c_o;
    assign dch[3] = d_o;

    int passes = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: channel contents as plain arrays, slot as an integer,
    // completed frames as an unbounded integer, plus per-channel FIFOs of
    // words accepted but not yet delivered.
    int         m_slot;
    logic [7:0] m_d [4];
    logic [3:0] m_v;
    int         m_cnt;
    logic       m_err;
    logic [7:0] sb_q [4][$];
    logic       m_last_rdy, m_last_acc;

    task automatic model_reset();
        m_slot = 0; m_v = '0; m_cnt = 0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_d[i] = '0;
            sb_q[i].delete();
        end
    endtask

    // One clock cycle: apply inputs, check outputs before the edge, then
    // advance the model across the edge.
    task automatic cycle(input logic v, input logic sof, input logic [7:0] d,
                         input logic [3:0] rdy, input logic r);
        int         eff;
        logic       exp_rdy, acc;
        logic [7:0] exp_word;
        in_valid = v; in_sof = sof; in_data = d; out_ready = rdy; rst = r;
        #1;
        eff     = sof ? 0 : m_slot;
        exp_rdy = !m_v[eff] || rdy[eff];
        acc     = v && exp_rdy && !r;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        chk("out_valid", {28'b0, out_valid}, {28'b0, m_v});
        chk("A", {24'b0, a_o}, {24'b0, m_d[0]});
        chk("B", {24'b0, b_o}, {24'b0, m_d[1]});
        chk("C", {24'b0, c_o}, {24'b0, m_d[2]});
        chk("D", {24'b0, d_o}, {24'b0, m_d[3]});
        chk("slot", {30'b0, s1, s0}, 32'(m_slot));
        chk("frame_err", {31'b0, frame_err}, {31'b0, m_err});
        chk("frame_cnt", {24'b0, frame_cnt}, 32'(m_cnt % 256));
        chk("frame_cnt_w2", {30'b0, frame_cnt2}, 32'(m_cnt % 4));
        // Delivery order: every drained word must be the oldest undelivered
        // word accepted for that channel.
        for (int i = 0; i < 4; i++) begin
            if (!r && out_valid[i] && rdy[i]) begin
                if (sb_q[i].size() == 0) begin
                    chk($sformatf("sb_empty_ch%0d", i), 32'd1, 32'd0);
                end else begin
                    exp_word = sb_q[i].pop_front();
                    chk($sformatf("sb_ch%0d", i), {24'b0, dch[i]}, {24'b0, exp_word});
                end
            end
        end
        m_last_rdy = exp_rdy;
        m_last_acc = acc;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc && eff == i) begin
                    m_d[i] = d; m_v[i] = 1'b1;
                    sb_q[i].push_back(d);
                end else if (m_v[i] && rdy[i]) begin
                    m_v[i] = 1'b0;
                end
            end
            m_err = acc && sof && (m_slot != 0);
            if (acc) begin
                if (eff == 3) m_cnt++;
                m_slot = (eff + 1) % 4;
            end
        end
        #1;
    endtask

    // Directed vectors with hand-derived expectations (out_ready all high).
    typedef struct {
        logic       v;
        logic       sof;
        logic [7:0] d;
        logic       exp_rdy;
        logic [1:0] exp_slot;
        logic       exp_err;
        logic [7:0] exp_cnt;
        logic [3:0] exp_valid;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int         stall;
        int         budget;
        int         cnt_before;
        logic       saw_block;
        logic [7:0] w;
        logic [1:0] exp_w2 [5];

        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state (checked inside cycle against the zeroed model).
        cycle(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);
        $display("reset state checked");

        // Frame 0x11..0x44, idle, then a misaligned SOF on slot 2.
        vecs[0] = '{1, 1, 8'h11, 1, 2'd1, 0, 8'd0, 4'b0001};
        vecs[1] = '{1, 0, 8'h22, 1, 2'd2, 0, 8'd0, 4'b0010};
        vecs[2] = '{1, 0, 8'h33, 1, 2'd3, 0, 8'd0, 4'b0100};
        vecs[3] = '{1, 0, 8'h44, 1, 2'd0, 0, 8'd1, 4'b1000};
        vecs[4] = '{0, 0, 8'h00, 1, 2'd0, 0, 8'd1, 4'b0000};
        vecs[5] = '{1, 1, 8'hA1, 1, 2'd1, 0, 8'd1, 4'b0001};
        vecs[6] = '{1, 0, 8'hA2, 1, 2'd2, 0, 8'd1, 4'b0010};
        vecs[7] = '{1, 1, 8'h55, 1, 2'd1, 1, 8'd1, 4'b0001};
        vecs[8] = '{0, 0, 8'h00, 1, 2'd1, 0, 8'd1, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].v, vecs[i].sof, vecs[i].d, 4'hF, 1'b0);
            chk($sformatf("vec%0d_rdy", i), {31'b0, m_last_rdy}, {31'b0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_slot", i), {30'b0, s1, s0}, {30'b0, vecs[i].exp_slot});
            chk($sformatf("vec%0d_err", i), {31'b0, frame_err}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_cnt", i), {24'b0, frame_cnt}, {24'b0, vecs[i].exp_cnt});
            chk($sformatf("vec%0d_valid", i), {28'b0, out_valid}, {28'b0, vecs[i].exp_valid});
            if (vecs[i].v && vecs[i].exp_valid != 0) begin
                for (int c = 0; c < 4; c++)
                    if (vecs[i].exp_valid[c])
                        chk($sformatf("vec%0d_data", i), {24'b0, dch[c]}, {24'b0, vecs[i].d});
            end
            $display("vec %0d: d=0x%02h sof=%0b slot=%0d err=%0b cnt=%0d valid=%b",
                     i, vecs[i].d, vecs[i].sof, {s1, s0}, frame_err, frame_cnt, out_valid);
        end

        // Channel B stalled across two continuous frames.
        cnt_before = m_cnt;
        saw_block  = 1'b0;
        out_ready  = 4'b1101;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 4; s++) begin
                w = 8'h60 + 8'(f * 16) + 8'(s + 1);
                stall = 0;
                budget = 0;
                m_last_acc = 1'b0;
                while (!m_last_acc && budget < 20) begin
                    cycle(1'b1, s == 0, w, out_ready, 1'b0);
                    if (!m_last_rdy) begin
                        saw_block = 1'b1;
                        stall++;
                        if (stall >= 4) out_ready = 4'hF;
                    end
                    budget++;
                end
                if (!m_last_acc) chk("bp_budget", 32'd0, 32'd1);
                $display("bp word 0x%02h accepted after %0d cycles", w, budget);
            end
        end
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);
        chk("bp_blocked", {31'b0, saw_block}, 32'd1);
        chk("bp_cnt", {24'b0, frame_cnt}, 32'(cnt_before + 2));

        // Simultaneous drain and reload on channel C.
        cycle(1'b1, 1'b1, 8'h01, 4'b1011, 1'b0);
        cycle(1'b1, 1'b0, 8'h02, 4'b1011, 1'b0);
        cycle(1'b1, 1'b0, 8'h03, 4'b1011, 1'b0);
        cycle(1'b1, 1'b0, 8'h04, 4'b1011, 1'b0);
        cycle(1'b1, 1'b0, 8'h05, 4'b1011, 1'b0);
        cycle(1'b1, 1'b0, 8'h06, 4'b1011, 1'b0);
        chk("c_full", {31'b0, out_valid[2]}, 32'd1);
        cycle(1'b1, 1'b0, 8'h99, 4'hF, 1'b0);
        chk("c_reload_valid", {31'b0, out_valid[2]}, 32'd1);
        chk("c_reload_data", {24'b0, c_o}, 32'h99);
        $display("drain+reload C: valid=%0b C=0x%02h", out_valid[2], c_o);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);

        // Reset mid-operation discards buffered words.
        cycle(1'b1, 1'b1, 8'h81, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 8'h82, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        chk("rst_valid", {28'b0, out_valid}, 32'd0);
        chk("rst_A", {24'b0, a_o}, 32'd0);
        chk("rst_B", {24'b0, b_o}, 32'd0);
        chk("rst_slot", {30'b0, s1, s0}, 32'd0);
        chk("rst_cnt", {24'b0, frame_cnt}, 32'd0);
        cycle(1'b1, 1'b0, 8'h83, 4'hF, 1'b0);
        chk("post_rst_valid", {28'b0, out_valid}, 32'b0001);
        chk("post_rst_A", {24'b0, a_o}, 32'h83);
        $display("mid-op reset: valid=%b A=0x%02h", out_valid, a_o);

        // Counter wrap on the CNT_W=2 instance over five frames.
        cycle(1'b0, 1'b0, 8'h00, 4'hF, 1'b1);
        exp_w2[0] = 2'd1; exp_w2[1] = 2'd2; exp_w2[2] = 2'd3;
        exp_w2[3] = 2'd0; exp_w2[4] = 2'd1;
        for (int f = 0; f < 5; f++) begin
            for (int s = 0; s < 4; s++)
                cycle(1'b1, s == 0, 8'(f * 4 + s), 4'hF, 1'b0);
            chk($sformatf("wrap_f%0d", f), {30'b0, frame_cnt2}, {30'b0, exp_w2[f]});
            $display("frame %0d: frame_cnt(w2)=%0d", f, frame_cnt2);
        end

        // Randomized traffic with occasional SOF, stalls and resets.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  8'($urandom), 4'($urandom), $urandom_range(0, 63) == 0);
        end
        $display("random phase done");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
